// File: rtl/ws2812b_in_module_pkg.sv
// ws2812b receive decoder: shared constants and types.
// Transmit-side constants live here too so both ends agree.
package ws2812b_in_module_pkg;

  localparam int WORD_W = 24;

  localparam int DEF_BIT_THRESHOLD = 5;
  localparam int DEF_HIGH_MIN      = 2;
  localparam int DEF_HIGH_MAX      = 12;
  localparam int DEF_RET_MIN       = 200;
  localparam int DEF_CNT_WIDTH     = 9;

  localparam int CYCLES_SHORT = 4;
  localparam int CYCLES_LONG  = 6;
  localparam int CYCLES_RET   = 451;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } rx_state_t;

endpackage

// File: rtl/ws2812b_in_module_if.sv
// ws2812b receive decoder: decoded-word valid/ready channel.
// The decoder is master, the word consumer is slave.
interface ws2812b_in_module_if;
  import ws2812b_in_module_pkg::*;

  word_t word_out;
  logic  word_valid;
  logic  word_ready;

  modport master (
    output word_out,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_out,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/ws2812b_in_module_pulse_meter.sv
// ws2812b_pulse_meter: line synchronizer, edge detect and
// saturating level-width counter.
module ws2812b_pulse_meter #(
  parameter int CNT_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 din,
  output logic                 level,
  output logic                 rise,
  output logic                 fall,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic s1;
  logic s;
  logic s_q;
  logic edge_s;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1  <= 1'b0;
      s   <= 1'b0;
      s_q <= 1'b0;
    end else begin
      s1  <= din;
      s   <= s1;
      s_q <= s;
    end
  end

  assign edge_s = s ^ s_q;
  assign rise   = s & ~s_q;
  assign fall   = ~s & s_q;
  assign level  = s;

  // On an edge cycle cnt still holds the width of the level just ended.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (edge_s) begin
      cnt <= CNT_WIDTH'(1);
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ws2812b_in_module.sv
// ws2812b receive decoder: pulse classification FSM, MSB-first
// shifter and single-entry output word register.
module ws2812b_in_module
  import ws2812b_in_module_pkg::*;
#(
  parameter int CYCLES_BIT_THRESHOLD = DEF_BIT_THRESHOLD,
  parameter int CYCLES_HIGH_MIN      = DEF_HIGH_MIN,
  parameter int CYCLES_HIGH_MAX      = DEF_HIGH_MAX,
  parameter int CYCLES_RET_MIN       = DEF_RET_MIN,
  parameter int CYCLES_CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ws2812b_in,
  ws2812b_in_module_if.master word_if,
  output logic                frame_end,
  output logic                bit_error,
  output logic                overflow
);

  localparam int CW = CYCLES_CNT_WIDTH;
  localparam logic [CW-1:0] THR_C = CW'(CYCLES_BIT_THRESHOLD);
  localparam logic [CW-1:0] MIN_C = CW'(CYCLES_HIGH_MIN);
  localparam logic [CW-1:0] MAX_C = CW'(CYCLES_HIGH_MAX);
  localparam logic [CW-1:0] RET_C = CW'(CYCLES_RET_MIN);
  localparam logic [4:0] LAST_BIT = 5'(WORD_W - 1);

  logic          level;
  logic          rise;
  logic          fall;
  logic [CW-1:0] cnt;

  rx_state_t state;
  rx_state_t state_n;
  word_t     sr;
  word_t     sr_n;
  logic [4:0] bitnum;

  logic do_shift;
  logic discard;
  logic fe_c;
  logic err_c;
  logic complete;
  logic load;

  ws2812b_pulse_meter #(
    .CNT_WIDTH(CW)
  ) u_meter (
    .clk   (clk),
    .resetn(resetn),
    .din   (ws2812b_in),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .cnt   (cnt)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_SYNC;
    else         state <= state_n;
  end

  always_comb begin
    state_n  = state;
    do_shift = 1'b0;
    discard  = 1'b0;
    fe_c     = 1'b0;
    err_c    = 1'b0;
    unique case (state)
      ST_SYNC: begin
        if (!level && !fall && cnt >= RET_C)
          state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (rise) state_n = ST_HIGH;
      end
      ST_HIGH: begin
        if (cnt > MAX_C) begin
          err_c   = 1'b1;
          discard = 1'b1;
          state_n = ST_SYNC;
        end else if (fall) begin
          do_shift = (cnt >= MIN_C);
          state_n  = ST_LOW;
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_n = ST_HIGH;
        end else if (cnt >= RET_C) begin
          fe_c    = 1'b1;
          err_c   = (bitnum != 5'd0);
          discard = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_SYNC;
    endcase
  end

  assign sr_n     = {sr[WORD_W-2:0], cnt >= THR_C};
  assign complete = do_shift && (bitnum == LAST_BIT);
  assign load     = complete &&
                    (!word_if.word_valid || word_if.word_ready);

  assign frame_end = resetn && fe_c;
  assign bit_error = resetn && err_c;
  assign overflow  = resetn && complete && !load;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sr     <= '0;
      bitnum <= '0;
    end else if (discard) begin
      sr     <= '0;
      bitnum <= '0;
    end else if (do_shift) begin
      sr     <= sr_n;
      bitnum <= complete ? 5'd0 : bitnum + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      word_if.word_out   <= '0;
      word_if.word_valid <= 1'b0;
    end else if (load) begin
      word_if.word_out   <= sr_n;
      word_if.word_valid <= 1'b1;
    end else if (word_if.word_valid && word_if.word_ready) begin
      word_if.word_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ws2812b_in_module.sv
// ws2812b receive decoder bench: waveform segments drive the
// line and an event-level protocol model predicts the results.
module tb_ws2812b_in_module;
  import ws2812b_in_module_pkg::*;

  localparam int THR  = 5;
  localparam int HMIN = 2;
  localparam int HMAX = 12;
  localparam int RET  = 200;
  localparam int LATCH = 451;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic pin = 1'b0;
  logic fe;
  logic be;
  logic ovf;

  ws2812b_in_module_if wif();

  ws2812b_in_module dut (
    .clk       (clk),
    .resetn    (resetn),
    .ws2812b_in(pin),
    .word_if   (wif.master),
    .frame_end (fe),
    .bit_error (be),
    .overflow  (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_fe = 0;
  int n_be = 0;
  int n_ovf = 0;
  int n_both = 0;
  int vrise_cyc = 0;
  int fe_cyc = 0;
  logic v_q = 1'b0;
  word_t got[$];

  always @(negedge clk) begin
    if (fe) begin
      n_fe   <= n_fe + 1;
      fe_cyc <= cyc;
    end
    if (be) n_be <= n_be + 1;
    if (ovf) n_ovf <= n_ovf + 1;
    if (fe && be) n_both <= n_both + 1;
    if (wif.word_valid && !v_q) vrise_cyc <= cyc;
    v_q <= wif.word_valid;
    if (wif.word_valid && wif.word_ready)
      got.push_back(wif.word_out);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string tag, logic [31:0] a,
                       logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, a, e);
    end
  endtask

  // protocol model state
  bit    m_sync;
  bit    m_inf;
  bit    m_rdy;
  bit    m_held;
  int    m_low;
  int    m_bits;
  word_t m_acc;
  word_t exp_q[$];
  int e_fe = 0;
  int e_be = 0;
  int e_ovf = 0;
  int e_both = 0;
  int w_idx = 0;
  int last_fall = 0;

  bit sq_lvl[$];
  int sq_len[$];

  task automatic deliver(word_t w);
    if (m_rdy || !m_held) begin
      exp_q.push_back(w);
      if (!m_rdy) m_held = 1'b1;
    end else begin
      e_ovf++;
    end
  endtask

  task automatic model_seg(bit l, int n);
    if (!l) begin
      int prev = m_low;
      m_low += n;
      if (prev < RET && m_low >= RET) begin
        if (!m_sync) begin
          m_sync = 1'b1;
        end else if (m_inf) begin
          e_fe++;
          if (m_bits != 0) begin
            e_be++;
            e_both++;
          end
          m_bits = 0;
          m_inf  = 1'b0;
        end
      end
    end else begin
      m_low = 0;
      if (m_sync) begin
        if (n > HMAX) begin
          e_be++;
          m_bits = 0;
          m_sync = 1'b0;
          m_inf  = 1'b0;
        end else begin
          m_inf = 1'b1;
          if (n >= HMIN) begin
            m_acc = {m_acc[22:0], n >= THR};
            m_bits++;
            if (m_bits == 24) begin
              m_bits = 0;
              deliver(m_acc);
            end
          end
        end
      end
    end
  endtask

  task automatic add(bit l, int n);
    int k = sq_len.size() - 1;
    if (k >= 0 && sq_lvl[k] == l) begin
      sq_len[k] = sq_len[k] + n;
    end else begin
      sq_lvl.push_back(l);
      sq_len.push_back(n);
    end
  endtask

  task automatic play();
    for (int i = 0; i < sq_lvl.size(); i++) begin
      model_seg(sq_lvl[i], sq_len[i]);
      if (pin && !sq_lvl[i]) last_fall = cyc;
      pin = sq_lvl[i];
      repeat (sq_len[i]) @(negedge clk);
    end
    sq_lvl.delete();
    sq_len.delete();
  endtask

  task automatic put_bit(bit b, bit nom);
    int h;
    int l;
    if (nom) begin
      h = b ? CYCLES_LONG : CYCLES_SHORT;
      l = CYCLES_LONG + CYCLES_SHORT - h;
    end else begin
      h = b ? int'($urandom_range(THR, HMAX))
            : int'($urandom_range(HMIN, THR - 1));
      l = int'($urandom_range(1, 20));
    end
    add(1'b1, h);
    add(1'b0, l);
  endtask

  task automatic put_word(word_t w, bit nom, bit gl);
    for (int i = 23; i >= 0; i--) begin
      put_bit(w[i], nom);
      if (gl && i > 0) begin
        add(1'b1, 1);
        add(1'b0, int'($urandom_range(1, 5)));
      end
    end
  endtask

  task automatic set_ready(bit r);
    m_rdy = r;
    wif.word_ready = r;
    if (r) m_held = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    pin = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    m_sync = 1'b0;
    m_inf  = 1'b0;
    m_bits = 0;
    m_low  = 0;
    m_held = 1'b0;
  endtask

  task automatic check_all(string tag);
    check({tag, " words"}, got.size(), exp_q.size());
    for (int i = w_idx; i < got.size(); i++)
      if (i < exp_q.size())
        check({tag, " word"}, 32'(got[i]), 32'(exp_q[i]));
    w_idx = got.size();
    check({tag, " frame_end"}, n_fe, e_fe);
    check({tag, " bit_error"}, n_be, e_be);
    check({tag, " overflow"}, n_ovf, e_ovf);
    check({tag, " fe+err"}, n_both, e_both);
  endtask

  initial begin
    wif.word_ready = 1'b0;
    m_rdy = 1'b0;
    m_held = 1'b0;
    m_acc = '0;
    @(negedge clk);
    do_reset();
    check("rst word_out", 32'(wif.word_out), 0);
    check("rst valid", 32'(wif.word_valid), 0);
    check("rst frame_end", 32'(fe), 0);
    check("rst bit_error", 32'(be), 0);
    check("rst overflow", 32'(ovf), 0);

    set_ready(1'b0);
    add(1'b0, 250);
    put_word(24'hA5C3F0, 1'b1, 1'b0);
    add(1'b0, LATCH);
    play();
    repeat (3) @(negedge clk);
    check("nom valid", 32'(wif.word_valid), 1);
    check("nom word_out", 32'(wif.word_out), 32'hA5C3F0);
    check("nom valid lat", vrise_cyc - last_fall, 3);
    check("nom fe lat", fe_cyc - last_fall, RET + 2);
    set_ready(1'b1);
    repeat (2) @(negedge clk);
    check("nom valid drop", 32'(wif.word_valid), 0);
    check_all("nom");

    put_word(24'hFF0000, 1'b0, 1'b0);
    put_word(24'h00FF00, 1'b0, 1'b0);
    put_word(24'h0000FF, 1'b0, 1'b0);
    add(1'b0, LATCH);
    play();
    repeat (3) @(negedge clk);
    check_all("b2b");

    set_ready(1'b0);
    put_word(24'h123456, 1'b0, 1'b0);
    put_word(24'($urandom), 1'b0, 1'b0);
    add(1'b0, LATCH);
    play();
    check("ovf held", 32'(wif.word_out), 32'h123456);
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    check_all("ovf");

    put_word(24'h800001, 1'b0, 1'b1);
    add(1'b0, LATCH);
    play();
    repeat (3) @(negedge clk);
    check_all("glitch");

    for (int i = 0; i < 10; i++)
      put_bit(1'($urandom_range(0, 1)), 1'b0);
    add(1'b0, LATCH);
    play();
    check_all("partial");
    put_word(24'($urandom), 1'b0, 1'b0);
    add(1'b0, LATCH);
    play();
    repeat (3) @(negedge clk);
    check_all("after partial");

    for (int i = 0; i < 12; i++)
      put_bit(1'($urandom_range(0, 1)), 1'b0);
    play();
    do_reset();
    add(1'b0, 250);
    put_word(24'($urandom), 1'b0, 1'b0);
    add(1'b0, LATCH);
    play();
    repeat (3) @(negedge clk);
    check_all("reset");

    add(1'b1, 20);
    add(1'b0, 10);
    put_word(24'($urandom), 1'b0, 1'b0);
    add(1'b0, 250);
    put_word(24'($urandom), 1'b0, 1'b0);
    add(1'b0, LATCH);
    play();
    repeat (3) @(negedge clk);
    check_all("long high");

    for (int it = 0; it < 6; it++) begin
      int nw = int'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        add(1'b1, int'($urandom_range(13, 30)));
        add(1'b0, int'($urandom_range(1, 40)));
      end
      for (int w = 0; w < nw; w++)
        put_word(24'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        int nb = int'($urandom_range(1, 23));
        for (int b = 0; b < nb; b++)
          put_bit(1'($urandom_range(0, 1)), 1'b0);
      end
      add(1'b0, LATCH);
      play();
      repeat (3) @(negedge clk);
      check_all("random");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
